// File: rtl/hls_seq_pkg.sv
// -----------------------------------------------------------------------------
// hls_seq_pkg
//   Shared types for the HLS stage sequencer.
//   - seq_state_e : controller states (IDLE, SELECT, RUN, DONE)
//   - stage_idx_w : width of a stage index that can also hold NUM_STAGES
//                   (the "past the last stage" value used to finish a run)
// -----------------------------------------------------------------------------
package hls_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  // Index must represent 0..num_stages inclusive.
  function automatic int stage_idx_w(input int num_stages);
    return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/hls_sat_counter.sv
// -----------------------------------------------------------------------------
// hls_sat_counter
//   Saturating up-counter with synchronous clear.
//   Parameters : W   counter width
//                MAX value at which the count stops
//   Ports      : clock    rising-edge clock
//                reset    synchronous active-high reset
//                clear_i  force count to 0 (wins over inc_i)
//                inc_i    add one unless already at MAX
//                count_o  current count
// -----------------------------------------------------------------------------
module hls_sat_counter #(
  parameter int             W   = 32,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default assigned first so every path drives count_d (no latch).
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: state registers use <= so all flops sample pre-edge values together.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hls_stage_sequencer.sv
// -----------------------------------------------------------------------------
// hls_stage_sequencer
//   ap_ctrl_hs controller that runs NUM_STAGES HLS sub-pipelines strictly in
//   order, skipping stages whose enable bit was clear at start, counting RUN
//   cycles per stage and aborting the run if a stage exceeds TIMEOUT_CYCLES.
//   Ports:
//     clock, reset           clock; synchronous active-high reset
//     ap_start               kernel start level, accepted only in IDLE
//     stage_en               per-stage enable, captured at accept
//     ap_done / ap_ready     one-cycle end-of-run pulse (same cycle)
//     ap_idle                high only in IDLE
//     stage_start            ap_start to each sub-pipeline (one-hot or zero)
//     stage_ready/stage_done sub-pipeline handshake pulses
//     cur_stage              stage index being selected/run
//     stage_cycles           flattened per-stage RUN-cycle counters
//     err_timeout/err_stage  sticky watchdog flag and offending stage
// -----------------------------------------------------------------------------
module hls_stage_sequencer
  import hls_seq_pkg::*;
#(
  parameter  int NUM_STAGES     = 4,
  parameter  int CNT_W          = 32,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int IDX_W          = stage_idx_w(NUM_STAGES)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ap_start,
  input  logic [NUM_STAGES-1:0]       stage_en,
  output logic                        ap_done,
  output logic                        ap_ready,
  output logic                        ap_idle,
  output logic [NUM_STAGES-1:0]       stage_start,
  input  logic [NUM_STAGES-1:0]       stage_ready,
  input  logic [NUM_STAGES-1:0]       stage_done,
  output logic [IDX_W-1:0]            cur_stage,
  output logic [NUM_STAGES*CNT_W-1:0] stage_cycles,
  output logic                        err_timeout,
  output logic [IDX_W-1:0]            err_stage
);

  localparam bit               WD_EN    = TIMEOUT_CYCLES > 0;
  localparam int               WD_MAX   = WD_EN ? TIMEOUT_CYCLES : 1;
  localparam int               WD_W     = $clog2(WD_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES);

  seq_state_e            state_q, state_d;
  logic [NUM_STAGES-1:0] en_q, en_d;
  logic [NUM_STAGES-1:0] start_q, start_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic                  err_timeout_q, err_timeout_d;
  logic [IDX_W-1:0]      err_stage_q, err_stage_d;

  logic [NUM_STAGES-1:0] cur_onehot;
  logic                  accept, run_ready, run_done, timeout;
  logic [WD_W-1:0]       wd_count;

  // One-hot of the current stage; all zero once cur_q has moved past the
  // last stage, so handshakes can never match a nonexistent stage.
  assign cur_onehot = NUM_STAGES'(1) << cur_q;
  assign accept     = (state_q == IDLE) && ap_start;
  assign run_ready  = |(stage_ready & cur_onehot);
  assign run_done   = |(stage_done  & cur_onehot);

  // wd_count holds the RUN cycles before this one, so reaching LIMIT-1 here
  // means this is the LIMIT-th RUN cycle. A done in that same cycle wins.
  assign timeout = WD_EN && (state_q == RUN) && !run_done &&
                   (wd_count == WD_W'(WD_MAX - 1));

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage_cnt
    hls_sat_counter #(.W(CNT_W)) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .clear_i (accept),
      .inc_i   ((state_q == RUN) && cur_onehot[i]),
      .count_o (stage_cycles[i*CNT_W +: CNT_W])
    );
  end

  // Watchdog restarts from zero whenever the controller is outside RUN.
  hls_sat_counter #(.W(WD_W), .MAX(WD_W'(WD_MAX))) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear_i (state_q != RUN),
    .inc_i   (state_q == RUN),
    .count_o (wd_count)
  );

  always_comb begin
    state_d       = state_q;
    en_d          = en_q;
    start_d       = start_q;
    cur_d         = cur_q;
    err_timeout_d = err_timeout_q;
    err_stage_d   = err_stage_q;
    unique case (state_q)
      IDLE: begin
        start_d = '0;
        if (ap_start) begin
          en_d          = stage_en;
          cur_d         = '0;
          err_timeout_d = 1'b0;
          err_stage_d   = '0;
          state_d       = SELECT;
        end
      end
      SELECT: begin
        if (cur_q == LAST_IDX) begin
          state_d = DONE;
        end else if (|(en_q & cur_onehot)) begin
          start_d = cur_onehot;
          state_d = RUN;
        end else begin
          cur_d = cur_q + IDX_W'(1);
        end
      end
      RUN: begin
        // Same as HLS ap_start_reg: drop start the cycle after ready.
        if (run_ready || run_done || timeout) begin
          start_d = '0;
        end
        if (timeout) begin
          err_timeout_d = 1'b1;
          err_stage_d   = cur_q;
          state_d       = DONE;
        end else if (run_done) begin
          cur_d   = cur_q + IDX_W'(1);
          state_d = SELECT;
        end
      end
      DONE: begin
        start_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      en_q          <= '0;
      start_q       <= '0;
      cur_q         <= '0;
      err_timeout_q <= 1'b0;
      err_stage_q   <= '0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      start_q       <= start_d;
      cur_q         <= cur_d;
      err_timeout_q <= err_timeout_d;
      err_stage_q   <= err_stage_d;
    end
  end

  assign ap_idle     = (state_q == IDLE);
  assign ap_done     = (state_q == DONE);
  assign ap_ready    = (state_q == DONE);
  assign stage_start = start_q;
  assign cur_stage   = cur_q;
  assign err_timeout = err_timeout_q;
  assign err_stage   = err_stage_q;

endmodule

// File: tb/tb_hls_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hls_stage_sequencer
//   Bench for hls_stage_sequencer with 4 stages, 3-bit counters (so saturation
//   at 7 is reachable) and an 8-cycle watchdog. Each run is described by a
//   plan (enable mask, RUN cycle of ready and of done per stage, 0 = never).
//   The reference model turns the plan into the expected cycle-by-cycle
//   waveform: accept cycle, one SELECT per stage index, the RUN cycles of each
//   enabled stage, the final SELECT, then DONE.
// -----------------------------------------------------------------------------
module tb_hls_stage_sequencer;

  localparam int N     = 4;
  localparam int CW    = 3;
  localparam int LIMIT = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           ap_start = 1'b0;
  logic [N-1:0]   stage_en = '0;
  logic           ap_done, ap_ready, ap_idle;
  logic [N-1:0]   stage_start;
  logic [N-1:0]   stage_ready = '0;
  logic [N-1:0]   stage_done = '0;
  logic [2:0]     cur_stage;
  logic [N*CW-1:0] stage_cycles;
  logic           err_timeout;
  logic [2:0]     err_stage;

  hls_stage_sequencer #(.NUM_STAGES(N), .CNT_W(CW), .TIMEOUT_CYCLES(LIMIT)) dut (
    .clock        (clock),
    .reset        (reset),
    .ap_start     (ap_start),
    .stage_en     (stage_en),
    .ap_done      (ap_done),
    .ap_ready     (ap_ready),
    .ap_idle      (ap_idle),
    .stage_start  (stage_start),
    .stage_ready  (stage_ready),
    .stage_done   (stage_done),
    .cur_stage    (cur_stage),
    .stage_cycles (stage_cycles),
    .err_timeout  (err_timeout),
    .err_stage    (err_stage)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [N-1:0] start;
    logic         idle;
    logic         done;
    logic         chk_cur;
    logic [2:0]   cur;
    logic [N-1:0] rdy;
    logic [N-1:0] dn;
    logic [N-1:0] quiet;  // bits that must carry no random handshake noise
  } cyc_t;

  int    errors = 0;
  int    checks = 0;
  string cur_test = "";

  logic [N-1:0] plan_en;
  int           plan_d [N];
  int           plan_r [N];
  int           last_latency;

  function automatic cyc_t mk(input logic [N-1:0] start, input logic idle,
                              input logic done, input logic chk, input logic [2:0] cur,
                              input logic [N-1:0] rdy, input logic [N-1:0] dn,
                              input logic [N-1:0] quiet);
    cyc_t c;
    c.start = start; c.idle = idle; c.done = done; c.chk_cur = chk; c.cur = cur;
    c.rdy = rdy; c.dn = dn; c.quiet = quiet;
    return c;
  endfunction

  // Drive one run from the plan and check it against the expected waveform.
  // Starts at a cycle where the DUT is idle; keep_start leaves ap_start high
  // after DONE so the next run is accepted back-to-back.
  task automatic run_plan(input bit keep_start);
    cyc_t         tl[$];
    int           exp_cnt [N];
    bit           to_hit;
    int           to_stage;
    logic [N-1:0] seen, exp_seen, b, nr, nd;
    logic [5:0]   obs, expv;
    int           done_at;
    to_hit = 0; to_stage = 0; seen = '0; exp_seen = '0; done_at = -1;
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;

    tl.push_back(mk('0, 1'b1, 1'b0, 1'b0, 3'd0, '0, '0, '0));
    for (int i = 0; i < N && !to_hit; i++) begin
      b = N'(1) << i;
      tl.push_back(mk('0, 1'b0, 1'b0, 1'b1, 3'(i), '0, '0, '0));
      if (plan_en[i]) begin
        exp_seen |= b;
        for (int k = 1; k <= LIMIT; k++) begin
          tl.push_back(mk((plan_r[i] == 0 || k <= plan_r[i]) ? b : '0, 1'b0, 1'b0,
                          1'b1, 3'(i), (k == plan_r[i]) ? b : '0,
                          (k == plan_d[i]) ? b : '0, b));
          exp_cnt[i] = (k > CMAX) ? CMAX : k;
          if (k == plan_d[i]) break;
          if (k == LIMIT) begin to_hit = 1; to_stage = i; end
        end
      end
    end
    if (!to_hit) tl.push_back(mk('0, 1'b0, 1'b0, 1'b1, 3'(N), '0, '0, '0));
    tl.push_back(mk('0, 1'b0, 1'b1, 1'b0, 3'd0, '0, '0, '0));

    for (int c = 0; c < tl.size(); c++) begin
      @(negedge clock);
      obs  = {stage_start, ap_idle, ap_done};
      expv = {tl[c].start, tl[c].idle, tl[c].done};
      checks++;
      if (obs !== expv || ap_ready !== tl[c].done) begin
        errors++;
        $display("FAIL %s ctrl cyc=%0d got start/idle/done=%b ready=%b, want %b ready=%b",
                 cur_test, c, obs, ap_ready, expv, tl[c].done);
      end
      if (tl[c].chk_cur) begin
        checks++;
        if (cur_stage !== tl[c].cur) begin
          errors++;
          $display("FAIL %s cur_stage cyc=%0d got %0d want %0d", cur_test, c, cur_stage, tl[c].cur);
        end
      end
      if (c == 1) begin
        checks++;
        if ({err_timeout, err_stage, stage_cycles} !== '0) begin
          errors++;
          $display("FAIL %s cleared_at_accept got err=%b stage=%0d cycles=%h want all 0",
                   cur_test, err_timeout, err_stage, stage_cycles);
        end
      end
      seen |= stage_start;
      if (ap_done === 1'b1 && done_at < 0) done_at = c;

      ap_start    = (c == tl.size() - 1) ? keep_start : 1'b1;
      stage_en    = (c == 0) ? plan_en : N'($urandom);
      nr          = N'($urandom);
      nd          = N'($urandom);
      stage_ready = tl[c].rdy | (nr & ~tl[c].quiet);
      stage_done  = tl[c].dn  | (nd & ~tl[c].quiet);
    end

    for (int i = 0; i < N; i++) begin
      checks++;
      if (stage_cycles[i*CW +: CW] !== CW'(exp_cnt[i])) begin
        errors++;
        $display("FAIL %s stage_cycles[%0d] got %0d want %0d", cur_test, i,
                 stage_cycles[i*CW +: CW], exp_cnt[i]);
      end
    end
    checks++;
    if (err_timeout !== to_hit || (to_hit && err_stage !== 3'(to_stage))) begin
      errors++;
      $display("FAIL %s watchdog got err=%b stage=%0d want err=%b stage=%0d",
               cur_test, err_timeout, err_stage, to_hit, to_stage);
    end
    checks++;
    if (seen !== exp_seen) begin
      errors++;
      $display("FAIL %s started_set got %b want %b", cur_test, seen, exp_seen);
    end
    checks++;
    if (done_at != tl.size() - 1) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", cur_test, done_at, tl.size() - 1);
    end
    last_latency = done_at;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    reset = 1'b1; ap_start = 1'b1; stage_en = '1; stage_ready = '1; stage_done = '1;
    repeat (3) @(negedge clock);
    checks++;
    if ({ap_idle, ap_done, ap_ready, stage_start} !== {1'b1, 1'b0, 1'b0, 4'b0}) begin
      errors++;
      $display("FAIL reset ctrl got idle/done/ready/start=%b want 1000000",
               {ap_idle, ap_done, ap_ready, stage_start});
    end
    checks++;
    if ({cur_stage, stage_cycles, err_timeout, err_stage} !== '0) begin
      errors++;
      $display("FAIL reset regs got cur=%0d cycles=%h err=%b stage=%0d want all 0",
               cur_stage, stage_cycles, err_timeout, err_stage);
    end
    reset = 1'b0; ap_start = 1'b0; stage_ready = '0; stage_done = '0;
    @(negedge clock);
    checks++;
    if (ap_idle !== 1'b1 || stage_start !== '0) begin
      errors++;
      $display("FAIL reset idle_after_release got idle=%b start=%b want 1 0000", ap_idle, stage_start);
    end
  endtask

  task automatic test_all_enabled();
    cur_test = "all_enabled";
    plan_en = 4'b1111;
    for (int i = 0; i < N; i++) begin plan_d[i] = 5; plan_r[i] = $urandom_range(1, 5); end
    run_plan(1'b0);
    checks++;
    if (last_latency != 26) begin
      errors++;
      $display("FAIL all_enabled done_after_accept got %0d want 26", last_latency);
    end
  endtask

  task automatic test_skip_mask();
    cur_test = "skip_mask";
    plan_en = 4'b0101;
    for (int i = 0; i < N; i++) begin
      plan_d[i] = $urandom_range(1, LIMIT); plan_r[i] = $urandom_range(0, LIMIT);
    end
    run_plan(1'b0);
  endtask

  task automatic test_ready_done_same();
    cur_test = "ready_done_same";
    plan_en = 4'b1111;
    for (int i = 0; i < N; i++) begin plan_d[i] = 3; plan_r[i] = 2; end
    plan_d[1] = 1; plan_r[1] = 1;
    run_plan(1'b0);
  endtask

  // Timeout run left with ap_start high, immediately followed by a clean run:
  // the second run must be accepted in the IDLE cycle and start from clean
  // counters and error flags.
  task automatic test_timeout_back_to_back();
    cur_test = "timeout";
    plan_en = 4'b1111;
    plan_d[0] = 3; plan_d[1] = 4; plan_d[2] = 0; plan_d[3] = 2;
    for (int i = 0; i < N; i++) plan_r[i] = $urandom_range(1, LIMIT);
    run_plan(1'b1);
    cur_test = "back_to_back";
    for (int i = 0; i < N; i++) begin
      plan_d[i] = $urandom_range(1, LIMIT); plan_r[i] = $urandom_range(0, LIMIT);
    end
    run_plan(1'b0);
  endtask

  // Done exactly at the watchdog limit is not a timeout, and 8 RUN cycles
  // saturate the 3-bit counter at 7. An all-disabled mask only walks SELECT.
  task automatic test_boundaries();
    cur_test = "done_at_limit";
    plan_en = 4'b1111;
    plan_d[0] = LIMIT; plan_d[1] = 1; plan_d[2] = LIMIT; plan_d[3] = 2;
    for (int i = 0; i < N; i++) plan_r[i] = 0;
    run_plan(1'b0);
    cur_test = "none_enabled";
    plan_en = 4'b0000;
    run_plan(1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      cur_test = $sformatf("random%0d", n);
      plan_en = N'($urandom);
      for (int i = 0; i < N; i++) begin
        plan_d[i] = $urandom_range(0, LIMIT); plan_r[i] = $urandom_range(0, LIMIT);
      end
      run_plan(1'($urandom));
    end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    cur_test = "reset_mid_run";
    found = 0;
    @(negedge clock);
    ap_start = 1'b1; stage_en = 4'b1111; stage_ready = '0; stage_done = '0;
    for (int g = 0; g < 30 && !found; g++) begin
      @(negedge clock);
      if (stage_start[1] === 1'b1) begin
        found = 1;
        stage_ready = '0; stage_done = '0;
      end else begin
        stage_ready = stage_start & 4'b1101;
        stage_done  = stage_start & 4'b1101;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_run stage1_start got never want within 30 cycles");
    end
    @(negedge clock);
    reset = 1'b1; ap_start = 1'b0;
    @(negedge clock);
    checks++;
    if ({stage_start, ap_idle, ap_done} !== {4'b0, 1'b1, 1'b0} ||
        {stage_cycles, err_timeout, cur_stage} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run after got start=%b idle=%b done=%b cycles=%h cur=%0d want 0000 1 0 0 0",
               stage_start, ap_idle, ap_done, stage_cycles, cur_stage);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_all_enabled();
    test_skip_mask();
    test_ready_done_same();
    test_timeout_back_to_back();
    test_boundaries();
    test_random();
    test_reset_mid_run();
    cur_test = "after_reset_run";
    plan_en = 4'b1011;
    for (int i = 0; i < N; i++) begin plan_d[i] = 2; plan_r[i] = 1; end
    run_plan(1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
